// File: rtl/mc_control_fsm_pkg.sv
// Shared opcode encodings and control-field encodings for the multicycle control FSM.
package mc_control_fsm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0, ALU_BRANCH = 2'd1, ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2
    } alu_src_b_t;

    // Opcodes that proceed from ID into EX; ECALL is decoded separately.
    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
               (op == OP_OP)   || (op == OP_OP_IMM) || (op == OP_JAL)  ||
               (op == OP_JALR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mc_control_fsm_if;
    import mc_control_fsm_pkg::*;

    logic [6:0] opcode;
    logic       bcond;
    logic       halt_cond;
    logic       mem_ready;

    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_source;
    logic       is_halted;
    logic       mem_err;
    logic       illegal;

    modport master (
        input  opcode, bcond, halt_cond, mem_ready,
        output ir_write, pc_write, reg_write, mem_read, mem_write, i_or_d,
               mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               is_halted, mem_err, illegal
    );

    modport slave (
        output opcode, bcond, halt_cond, mem_ready,
        input  ir_write, pc_write, reg_write, mem_read, mem_write, i_or_d,
               mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               is_halted, mem_err, illegal
    );

endinterface

// File: rtl/mc_control_fsm_perf.sv
// Performance counters (cycles, retired instructions) for mc_control_fsm; built only with PERF_CNT_EN.
module mc_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cycle_inc,
    input  logic             i_ret_inc,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret;

    // Both counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (i_cycle_inc) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (i_ret_inc)   r_instret   <= r_instret + CNT_W'(1);
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instret   = r_instret;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV control FSM (IF/ID/EX/MEM/WB/HALT) with memory wait timeout.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int WAIT_MAX = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master ctrl
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
`endif
);

    localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic              w_waiting;
    logic              w_timeout;

    // Completion in the limit cycle wins: w_waiting is already low when mem_ready is high.
    assign w_waiting = ((r_state == ST_IF) || (r_state == ST_MEM)) && !ctrl.mem_ready;
    assign w_timeout = (WAIT_MAX > 0) && w_waiting &&
                       (r_wait_cnt == WAIT_W'(WAIT_MAX - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IF;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_timeout) r_mem_err <= 1'b1;
            if (w_state_next != r_state)
                r_wait_cnt <= '0;
            else if (w_waiting && (r_wait_cnt != '1))
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        ctrl.ir_write   = 1'b0;
        ctrl.pc_write   = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.mem_read   = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.i_or_d     = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.pc_to_reg  = 1'b0;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.pc_source  = PC_PLUS4;
        ctrl.is_halted  = (r_state == ST_HALT);
        ctrl.mem_err    = r_mem_err;
        ctrl.illegal    = 1'b0;

        unique case (r_state)
            ST_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = ctrl.mem_ready;
                if (ctrl.mem_ready)  w_state_next = ST_ID;
                else if (w_timeout)  w_state_next = ST_HALT;
            end
            ST_ID: begin
                if (ctrl.opcode == OP_SYSTEM) begin
                    if (ctrl.halt_cond) begin
                        w_state_next = ST_HALT;
                    end else begin
                        ctrl.pc_write = 1'b1;
                        w_state_next  = ST_IF;
                    end
                end else if (is_exec_op(ctrl.opcode)) begin
                    w_state_next = ST_EX;
                end else begin
                    ctrl.illegal  = 1'b1;
                    ctrl.pc_write = 1'b1;
                    w_state_next  = ST_IF;
                end
            end
            ST_EX: begin
                case (ctrl.opcode)
                    OP_BRANCH: begin
                        ctrl.alu_op    = ALU_BRANCH;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = ctrl.bcond ? PC_IMM : PC_PLUS4;
                        w_state_next   = ST_IF;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        w_state_next   = ST_MEM;
                    end
                    OP_OP: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_FUNCT;
                        w_state_next   = ST_WB;
                    end
                    OP_OP_IMM: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        ctrl.alu_op    = ALU_FUNCT;
                        w_state_next   = ST_WB;
                    end
                    OP_JAL: begin
                        ctrl.alu_src_b = SRC_B_FOUR;
                        w_state_next   = ST_WB;
                    end
                    OP_JALR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        w_state_next   = ST_WB;
                    end
                    default: w_state_next = ST_IF;
                endcase
            end
            ST_MEM: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (ctrl.opcode == OP_LOAD);
                ctrl.mem_write = (ctrl.opcode == OP_STORE);
                if (ctrl.mem_ready) begin
                    if (ctrl.opcode == OP_LOAD) begin
                        w_state_next = ST_WB;
                    end else begin
                        ctrl.pc_write = 1'b1;
                        w_state_next  = ST_IF;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (ctrl.opcode == OP_LOAD);
                ctrl.pc_to_reg  = (ctrl.opcode == OP_JAL) || (ctrl.opcode == OP_JALR);
                ctrl.pc_write   = 1'b1;
                if (ctrl.opcode == OP_JAL)       ctrl.pc_source = PC_IMM;
                else if (ctrl.opcode == OP_JALR) ctrl.pc_source = PC_ALU;
                w_state_next = ST_IF;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_IF;
        endcase

        // Strobes are gated directly by reset so an in-flight access drops immediately.
        if (reset) begin
            ctrl.ir_write  = 1'b0;
            ctrl.pc_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.illegal   = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic w_cycle_inc;
    logic w_ret_inc;

    assign w_cycle_inc = (r_state != ST_HALT);
    assign w_ret_inc   = (w_state_next == ST_IF) && (r_state != ST_IF) && (r_state != ST_HALT);

    mc_perf_counter #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .i_cycle_inc (w_cycle_inc),
        .i_ret_inc   (w_ret_inc),
        .o_cycle_cnt (cycle_cnt),
        .o_instret   (instret)
    );
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: unlimited-wait and WAIT_MAX=4 instances side by side.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       is_halted;
        logic       mem_err;
        logic       illegal;
    } outs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mc_control_fsm_if if0 ();
    mc_control_fsm_if if4 ();

`ifdef PERF_CNT_EN
    logic [31:0] cyc0, ret0, cyc4, ret4;
    mc_control_fsm #(.WAIT_MAX(0)) dut0 (.clk(clk), .reset(reset), .ctrl(if0),
                                         .cycle_cnt(cyc0), .instret(ret0));
    mc_control_fsm #(.WAIT_MAX(4)) dut4 (.clk(clk), .reset(reset), .ctrl(if4),
                                         .cycle_cnt(cyc4), .instret(ret4));
`else
    mc_control_fsm #(.WAIT_MAX(0)) dut0 (.clk(clk), .reset(reset), .ctrl(if0));
    mc_control_fsm #(.WAIT_MAX(4)) dut4 (.clk(clk), .reset(reset), .ctrl(if4));
`endif

    outs_t o0, o4;
    assign o0 = {if0.ir_write, if0.pc_write, if0.reg_write, if0.mem_read, if0.mem_write,
                 if0.i_or_d, if0.mem_to_reg, if0.pc_to_reg, if0.alu_src_a, if0.alu_src_b,
                 if0.alu_op, if0.pc_source, if0.is_halted, if0.mem_err, if0.illegal};
    assign o4 = {if4.ir_write, if4.pc_write, if4.reg_write, if4.mem_read, if4.mem_write,
                 if4.i_or_d, if4.mem_to_reg, if4.pc_to_reg, if4.alu_src_a, if4.alu_src_b,
                 if4.alu_op, if4.pc_source, if4.is_halted, if4.mem_err, if4.illegal};

    // Expected output vectors per state, built from the control table.
    function automatic outs_t e_if(input logic rdy);
        outs_t e = '0;
        e.mem_read = 1'b1;
        e.ir_write = rdy;
        return e;
    endfunction

    function automatic outs_t e_id_pc(input logic ill);
        outs_t e = '0;
        e.pc_write = 1'b1;
        e.illegal  = ill;
        return e;
    endfunction

    function automatic outs_t e_ex(input logic a, input alu_src_b_t b, input alu_op_t op);
        outs_t e = '0;
        e.alu_src_a = a;
        e.alu_src_b = b;
        e.alu_op    = op;
        return e;
    endfunction

    function automatic outs_t e_br(input logic taken);
        outs_t e = '0;
        e.alu_op    = ALU_BRANCH;
        e.pc_write  = 1'b1;
        e.pc_source = taken ? PC_IMM : PC_PLUS4;
        return e;
    endfunction

    function automatic outs_t e_mem(input logic rd, input logic wr, input logic pcw);
        outs_t e = '0;
        e.i_or_d    = 1'b1;
        e.mem_read  = rd;
        e.mem_write = wr;
        e.pc_write  = pcw;
        return e;
    endfunction

    function automatic outs_t e_wb(input logic ld, input logic ptr, input pc_src_t src);
        outs_t e = '0;
        e.reg_write  = 1'b1;
        e.pc_write   = 1'b1;
        e.mem_to_reg = ld;
        e.pc_to_reg  = ptr;
        e.pc_source  = src;
        return e;
    endfunction

    function automatic outs_t e_halt(input logic err);
        outs_t e = '0;
        e.is_halted = 1'b1;
        e.mem_err   = err;
        return e;
    endfunction

    task automatic check(input string tag, input outs_t obs, input outs_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
`endif

    task automatic drive(input logic [6:0] op, input logic bc, input logic hc, input logic rdy);
        if0.opcode = op; if0.bcond = bc; if0.halt_cond = hc; if0.mem_ready = rdy;
        if4.opcode = op; if4.bcond = bc; if4.halt_cond = hc; if4.mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(OP_OP, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes_0", o0, '0);
        check("reset_strobes_4", o4, '0);
        reset = 1'b0;
        #1;

        // ADD: IF -> ID -> EX -> WB -> IF
        check("add_if", o0, e_if(1'b1));
        tick(); check("add_id", o0, '0);
        tick(); check("add_ex", o0, e_ex(1'b1, SRC_B_RS2, ALU_FUNCT));
        tick(); check("add_wb", o0, e_wb(1'b0, 1'b0, PC_PLUS4));
        tick(); check("add_back_if", o0, e_if(1'b1));
`ifdef PERF_CNT_EN
        check_cnt("add_instret", ret0, 32'd1);
        check_cnt("add_cycles", cyc0, 32'd4);
`endif

        // LW with three wait cycles in MEM; completion lands at the WAIT_MAX boundary of dut4
        drive(OP_LOAD, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("lw_ex", o0, e_ex(1'b1, SRC_B_IMM, ALU_ADD));
        drive(OP_LOAD, 1'b0, 1'b0, 1'b0);
        tick(); check("lw_mem1", o0, e_mem(1'b1, 1'b0, 1'b0));
        tick(); check("lw_mem2", o0, e_mem(1'b1, 1'b0, 1'b0));
        tick(); check("lw_mem3", o0, e_mem(1'b1, 1'b0, 1'b0));
        tick(); drive(OP_LOAD, 1'b0, 1'b0, 1'b1);
        check("lw_mem4", o0, e_mem(1'b1, 1'b0, 1'b0));
        check("lw_mem4_limit", o4, e_mem(1'b1, 1'b0, 1'b0));
        tick(); check("lw_wb", o0, e_wb(1'b1, 1'b0, PC_PLUS4));
        check("lw_wb_limit_no_err", o4, e_wb(1'b1, 1'b0, PC_PLUS4));
        tick();

        // BEQ taken then not taken, no WB either time
        drive(OP_BRANCH, 1'b1, 1'b0, 1'b1);
        tick();
        tick(); check("beq_t_ex", o0, e_br(1'b1));
        tick(); check("beq_t_no_wb", o0, e_if(1'b1));
        drive(OP_BRANCH, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("beq_nt_ex", o0, e_br(1'b0));
        tick(); check("beq_nt_no_wb", o0, e_if(1'b1));

        // JAL, JALR, ADDI
        drive(OP_JAL, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("jal_ex", o0, e_ex(1'b0, SRC_B_FOUR, ALU_ADD));
        tick(); check("jal_wb", o0, e_wb(1'b0, 1'b1, PC_IMM));
        tick(); drive(OP_JALR, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("jalr_ex", o0, e_ex(1'b1, SRC_B_IMM, ALU_ADD));
        tick(); check("jalr_wb", o0, e_wb(1'b0, 1'b1, PC_ALU));
        tick(); drive(OP_OP_IMM, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("addi_ex", o0, e_ex(1'b1, SRC_B_IMM, ALU_FUNCT));
        tick();
        tick();

        // SW completing immediately
        drive(OP_STORE, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); check("sw_ex", o0, e_ex(1'b1, SRC_B_IMM, ALU_ADD));
        tick(); check("sw_mem", o0, e_mem(1'b0, 1'b1, 1'b1));
        tick(); check("sw_no_wb", o0, e_if(1'b1));

        // SW interrupted by reset while waiting in MEM
        tick();
        tick(); drive(OP_STORE, 1'b0, 1'b0, 1'b0);
        tick(); check("sw2_mem_wait", o0, e_mem(1'b0, 1'b1, 1'b0));
        #2 reset = 1'b1;
        #1 check("sw2_reset_async", o0, '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("sw2_if_after_reset", o0, e_if(1'b0));

        // IF never served: dut4 times out after its 4th wait cycle, dut0 waits forever
        check("to_if_cycle1", o4, e_if(1'b0));
        tick(); tick(); tick();
        check("to_if_cycle4", o4, e_if(1'b0));
        tick();
        check("to_halt", o4, e_halt(1'b1));
        check("to_unlimited", o0, e_if(1'b0));
        repeat (6) tick();
        check("unlimited_still_if", o0, e_if(1'b0));

        // ECALL without halt, illegal opcode, ECALL with halt
        drive(OP_SYSTEM, 1'b0, 1'b0, 1'b1);
        tick(); check("ecall_nohalt_id", o0, e_id_pc(1'b0));
        tick(); check("ecall_nohalt_if", o0, e_if(1'b1));
        drive(7'b1111111, 1'b0, 1'b0, 1'b1);
        tick(); check("illegal_id", o0, e_id_pc(1'b1));
        tick(); check("illegal_one_cycle", o0, e_if(1'b1));
        drive(OP_SYSTEM, 1'b0, 1'b1, 1'b1);
        tick(); check("ecall_halt_id", o0, '0);
        tick(); check("ecall_halt", o0, e_halt(1'b0));
        check("to_halt_sticky", o4, e_halt(1'b1));
        drive(OP_OP, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        check("halt_absorbing_0", o0, e_halt(1'b0));
        check("halt_absorbing_4", o4, e_halt(1'b1));

        // Only reset leaves HALT, and it clears mem_err
        reset = 1'b1;
        #1 check("halt_in_reset", o4, '0);
        tick();
        reset = 1'b0;
        #1;
        check("reset_exits_halt_4", o4, e_if(1'b1));
        check("reset_exits_halt_0", o0, e_if(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
